// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: major opcodes, the decoded-instruction
// record carried through the decode pipeline, and skid-buffer state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // The pc field is sized for the widest supported PC; narrower PCs are zero-extended.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [11:0]     imm12;
    logic            imm_valid;
    logic            illegal;
  } dec_instr_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm12_sel.sv
// Opcode-driven selection of the 12-bit immediate handed to the extend unit,
// plus legality classification of the major opcode.
module imm12_sel
  import rv32_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [11:0] i_imm_i,   // instr[31:20]
  input  logic [4:0]  s_lo_i,    // instr[11:7]
  output logic [11:0] imm12_o,
  output logic        imm_valid_o,
  output logic        illegal_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    imm12_o     = '0;
    imm_valid_o = 1'b0;
    illegal_o   = 1'b0;
    if (opcode_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opcode_i)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          imm12_o     = i_imm_i;
          imm_valid_o = 1'b1;
        end
        OPC_STORE: begin
          imm12_o     = {i_imm_i[11:5], s_lo_i};
          imm_valid_o = 1'b1;
        end
        OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH: ;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes on the input side and stores the
// decoded record in a 2-entry skid buffer so in_ready never depends on out_ready.
module id_stage
  import rv32_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [11:0]     imm12,
  output logic            imm_valid,
  output logic            illegal
);

  buf_state_e state_q, state_d;
  dec_instr_t main_q, main_d;
  dec_instr_t skid_q, skid_d;
  dec_instr_t dec;
  logic       in_ready_q;
  logic       in_fire;
  logic       out_fire;

  imm12_sel u_imm12_sel (
    .opcode_i    (in_instr[6:0]),
    .i_imm_i     (in_instr[31:20]),
    .s_lo_i      (in_instr[11:7]),
    .imm12_o     (dec.imm12),
    .imm_valid_o (dec.imm_valid),
    .illegal_o   (dec.illegal)
  );

  assign dec.pc     = XLEN'(in_pc);
  assign dec.opcode = in_instr[6:0];
  assign dec.rd     = in_instr[11:7];
  assign dec.funct3 = in_instr[14:12];
  assign dec.rs1    = in_instr[19:15];
  assign dec.rs2    = in_instr[24:20];
  assign dec.funct7 = in_instr[31:25];

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_fire) begin
            main_d  = dec;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            main_d = dec;
          end else if (out_fire) begin
            state_d = BUF_EMPTY;
          end else if (in_fire) begin
            skid_d  = dec;
            state_d = BUF_FULL;
          end
        end
        BUF_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: both buffer entries are cleared on reset because the field outputs must read zero afterwards.
      state_q    <= BUF_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != BUF_FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_pc    = PC_W'(main_q.pc);
  assign opcode    = main_q.opcode;
  assign rd        = main_q.rd;
  assign funct3    = main_q.funct3;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign funct7    = main_q.funct7;
  assign imm12     = main_q.imm12;
  assign imm_valid = main_q.imm_valid;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode fields, immediates,
// skid-buffer backpressure, flush and reset behaviour.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  logic        imm_valid;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  logic [31:0] out_log[$];

  localparam logic [31:0] I_ADDI = 32'hABC30293;  // addi x5,x6,0xABC
  localparam logic [31:0] I_SW   = 32'h7E742A23;  // sw x7,0x7F4(x8)

  // Back-to-back stream: instruction, expected imm12, imm_valid, illegal.
  logic [31:0] bb_instr[7] = '{32'hABC30293, 32'h12345537, 32'hFFC22183, 32'h123100E7,
                               32'h00208463, 32'h7E742A23, 32'h0000006B};
  logic [11:0] bb_imm[7]   = '{12'hABC, 12'h000, 12'hFFC, 12'h123, 12'h000, 12'h7F4, 12'h000};
  logic        bb_iv[7]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        bb_ill[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  id_stage #(.PC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct7    (funct7),
    .imm12     (imm12),
    .imm_valid (imm_valid),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Logs output transfers from stable pre-edge values, then advances one cycle.
  task automatic tick();
    if (out_valid && out_ready && !rst && !flush) out_log.push_back(out_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_hi: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if ({out_pc, funct7, rs2, rs1, funct3, rd, opcode, imm12, imm_valid, illegal} !== '0) begin
      bad++; $display("FAIL reset_fields: pc=%h op=%h imm=%h want all 0", out_pc, opcode, imm12); end
    rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h40;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    total++; if ({opcode, rd, funct3, rs1} !== {7'h13, 5'd5, 3'd0, 5'd6}) begin
      bad++; $display("FAIL addi_regs: op=%h rd=%0d f3=%0d rs1=%0d want 13/5/0/6", opcode, rd, funct3, rs1); end
    total++; if ({imm12, imm_valid, illegal} !== {12'hABC, 1'b1, 1'b0}) begin
      bad++; $display("FAIL addi_imm: imm=%h iv=%b ill=%b want abc/1/0", imm12, imm_valid, illegal); end
    total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL addi_pc: got %h want 40", out_pc); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_store();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = I_SW; in_pc = 32'h44;
    tick();
    in_valid = 1'b0;
    total++; if ({imm12, imm_valid, illegal} !== {12'h7F4, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sw_imm: imm=%h iv=%b ill=%b want 7f4/1/0", imm12, imm_valid, illegal); end
    total++; if ({rs1, rs2, funct3, opcode} !== {5'd8, 5'd7, 3'd2, 7'h23}) begin
      bad++; $display("FAIL sw_regs: rs1=%0d rs2=%0d f3=%0d op=%h want 8/7/2/23", rs1, rs2, funct3, opcode); end
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h80;
    tick();
    in_instr = 32'h00000000; in_pc = 32'h84;
    total++; if ({out_valid, illegal, imm12, imm_valid, out_pc} !== {1'b1, 1'b1, 12'h000, 1'b0, 32'h80}) begin
      bad++; $display("FAIL illegal_ones: v=%b ill=%b imm=%h iv=%b pc=%h want 1/1/000/0/80",
                      out_valid, illegal, imm12, imm_valid, out_pc); end
    tick();
    in_instr = I_ADDI; in_pc = 32'h88;
    total++; if ({out_valid, illegal, imm12, imm_valid, out_pc} !== {1'b1, 1'b1, 12'h000, 1'b0, 32'h84}) begin
      bad++; $display("FAIL illegal_zero: v=%b ill=%b imm=%h iv=%b pc=%h want 1/1/000/0/84",
                      out_valid, illegal, imm12, imm_valid, out_pc); end
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, illegal, imm12, imm_valid, out_pc} !== {1'b1, 1'b0, 12'hABC, 1'b1, 32'h88}) begin
      bad++; $display("FAIL illegal_recover: v=%b ill=%b imm=%h iv=%b pc=%h want 1/0/abc/1/88",
                      out_valid, illegal, imm12, imm_valid, out_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_instr = bb_instr[i]; in_pc = 32'h200 + 32'(4 * i);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      total++; if ({out_valid, out_pc} !== {1'b1, 32'h200 + 32'(4 * i)}) begin
        bad++; $display("FAIL b2b_pc[%0d]: v=%b pc=%h want 1/%h", i, out_valid, out_pc, 32'h200 + 32'(4 * i)); end
      total++; if ({funct7, rs2, rs1, funct3, rd, opcode} !== bb_instr[i]) begin
        bad++; $display("FAIL b2b_fields[%0d]: got %h want %h", i, {funct7, rs2, rs1, funct3, rd, opcode}, bb_instr[i]); end
      total++; if ({imm12, imm_valid, illegal} !== {bb_imm[i], bb_iv[i], bb_ill[i]}) begin
        bad++; $display("FAIL b2b_imm[%0d]: imm=%h iv=%b ill=%b want %h/%b/%b",
                        i, imm12, imm_valid, illegal, bb_imm[i], bb_iv[i], bb_ill[i]); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    total++; if (out_log.size() !== 7) begin bad++; $display("FAIL b2b_count: got %0d want 7", out_log.size()); end
  endtask

  task automatic test_backpressure();
    out_log.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h0;
    tick();
    in_pc = 32'h4;
    total++; if ({in_ready, out_valid, out_pc} !== {1'b1, 1'b1, 32'h0}) begin
      bad++; $display("FAIL bp_one: rdy=%b v=%b pc=%h want 1/1/0", in_ready, out_valid, out_pc); end
    tick();
    in_pc = 32'h8;
    total++; if ({in_ready, out_pc} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL bp_full: rdy=%b pc=%h want 0/0", in_ready, out_pc); end
    tick();
    total++; if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h0}) begin
      bad++; $display("FAIL bp_hold: rdy=%b v=%b pc=%h want 0/1/0", in_ready, out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    total++; if ({in_ready, out_valid, out_pc} !== {1'b1, 1'b1, 32'h4}) begin
      bad++; $display("FAIL bp_drain1: rdy=%b v=%b pc=%h want 1/1/4", in_ready, out_valid, out_pc); end
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, out_pc} !== {1'b1, 32'h8}) begin
      bad++; $display("FAIL bp_drain2: v=%b pc=%h want 1/8", out_valid, out_pc); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    total++; if (out_log.size() !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", out_log.size()); end
    else begin
      total++; if ({out_log[0], out_log[1], out_log[2]} !== {32'h0, 32'h4, 32'h8}) begin
        bad++; $display("FAIL bp_order: got %h %h %h want 0 4 8", out_log[0], out_log[1], out_log[2]); end
    end
  endtask

  task automatic test_flush();
    out_log.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h300;
    tick();
    in_pc = 32'h304;
    tick();
    in_pc = 32'h308; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      bad++; $display("FAIL flush_full: v=%b rdy=%b want 0/1", out_valid, in_ready); end
    in_pc = 32'h30C;
    tick();
    in_pc = 32'h310; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      bad++; $display("FAIL flush_one: v=%b rdy=%b want 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    tick(); tick();
    total++; if (out_log.size() !== 0) begin bad++; $display("FAIL flush_leak: got %0d outputs want 0", out_log.size()); end
    in_valid = 1'b1; in_instr = I_SW; in_pc = 32'h320;
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, out_pc, imm12} !== {1'b1, 32'h320, 12'h7F4}) begin
      bad++; $display("FAIL flush_recover: v=%b pc=%h imm=%h want 1/320/7f4", out_valid, out_pc, imm12); end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_SW; in_pc = 32'h400;
    tick();
    in_pc = 32'h404;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstm_full: rdy=%b want 0", in_ready); end
    rst = 1'b1; in_pc = 32'h408;
    tick();
    total++; if ({out_valid, in_ready} !== {1'b0, 1'b0}) begin
      bad++; $display("FAIL rstm_during: v=%b rdy=%b want 0/0", out_valid, in_ready); end
    total++; if ({out_pc, funct7, rs2, rs1, funct3, rd, opcode, imm12, imm_valid, illegal} !== '0) begin
      bad++; $display("FAIL rstm_fields: pc=%h op=%h imm=%h iv=%b want all 0", out_pc, opcode, imm12, imm_valid); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    total++; if ({in_ready, out_valid} !== {1'b1, 1'b0}) begin
      bad++; $display("FAIL rstm_after: rdy=%b v=%b want 1/0", in_ready, out_valid); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstm_ghost: v=%b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode pipeline stage of the RV32I core. Sits directly upstream of the sign-extension unit.
- Accepts fetched instruction words over a valid/ready handshake and registers the decoded fields.
- Supplies the 12-bit immediate that the extend unit widens to 32 bits.
- Contains a 2-entry skid buffer so that backpressure does not create a combinational ready path to fetch.

Parameters:
- PC_W, 32, width of the program-counter field carried alongside each instruction.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards all buffered instructions (branch/jump redirect).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered, never combinational from out_ready.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  downstream (execute) accepts.
- out_pc  output  PC_W  PC of the decoded instruction.
- opcode  output  7  instr[6:0].
- rd  output  5  instr[11:7].
- funct3  output  3  instr[14:12].
- rs1  output  5  instr[19:15].
- rs2  output  5  instr[24:20].
- funct7  output  7  instr[31:25].
- imm12  output  12  immediate field feeding the extend unit.
- imm_valid  output  1  imm12 is meaningful for this opcode.
- illegal  output  1  unsupported or malformed encoding.

Behaviour:
- Handshake rules:
  - Transfer in occurs when in_valid and in_ready are both high.
  - Transfer out occurs when out_valid and out_ready are both high.
  - The upstream side must hold in_* stable while in_valid is high and in_ready is low.
- Decode happens before storage. Each buffer entry holds the fully decoded field set.
- Immediate selection:
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: imm12 = instr[31:20], imm_valid = 1.
  - STORE 0100011: imm12 = {instr[31:25], instr[11:7]}, imm_valid = 1.
  - OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, BRANCH 1100011: imm12 = 0, imm_valid = 0, illegal = 0.
  - Any other opcode, or instr[1:0] != 2'b11: illegal = 1, imm12 = 0, imm_valid = 0. The entry still passes through; the stage does not stall on it.
- Buffer states (main = output register, skid = overflow register):
  - EMPTY: out_valid = 0, in_ready = 1. A transfer in loads main and moves to ONE.
  - ONE: out_valid = 1, in_ready = 1.
    - In and out in the same cycle: main is reloaded; state stays ONE.
    - Out only: moves to EMPTY.
    - In only: loads skid and moves to FULL.
  - FULL: out_valid = 1, in_ready = 0.
    - A transfer out moves skid into main and moves to ONE.
    - No input can be accepted in this state.
- Latency: 1 cycle from a transfer in to out_valid, when the stage was EMPTY.
- Throughput: 1 instruction per cycle while out_ready stays high.
- Ordering: strictly FIFO. Instructions are never dropped except by flush or rst.
- Flush: next state is EMPTY.
  - Any transfer in during the flush cycle is discarded.
  - out_valid is 0 in the next cycle.
  - flush takes precedence over all handshakes in that cycle.
- Reset:
  - rst takes precedence over flush.
  - State becomes EMPTY; out_valid = 0 and all field outputs = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after rst deasserts.
  - Reset asserted mid-stream discards both entries.
- Field outputs are don't-care when out_valid = 0, except after reset, where they are 0.

Decomposition:
- Shared package rv32_pkg holds:
  - Opcode constants (OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH).
  - A packed decoded-instruction struct: pc, fields, imm12, imm_valid, illegal.
- One natural sub-module, imm12_sel: combinational opcode-to-imm12/imm_valid/illegal selection, instantiated once on the input path.
- The skid-buffer control stays in id_stage.

Test Plan:
- addi x5,x6,0xABC: in_instr=0xABC30293, out_ready=1 → next cycle out_valid=1, opcode=0x13, rd=5, rs1=6, funct3=0, imm12=0xABC, imm_valid=1, illegal=0.
- sw x7,0x7F4(x8): in_instr=0x7E742A23 → imm12=0x7F4, rs1=8, rs2=7, funct3=2, imm_valid=1.
- Backpressure: out_ready=0, send PC 0x0, 0x4, 0x8 back-to-back:
  - First two accepted; in_ready=0 from cycle 2; third held by fetch.
  - Raise out_ready → PCs emerge 0x0, 0x4, 0x8 in order, one per cycle, none lost or duplicated.
- Flush in FULL with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed and offered instructions never appear at the output.
- Illegal: in_instr=0xFFFFFFFF and 0x00000000 → out_valid=1, illegal=1, imm12=0, imm_valid=0. The next legal instruction is unaffected.
- Reset mid-stream: rst pulsed for 1 cycle while in FULL → out_valid=0, all fields 0, in_ready=0 during rst and 1 the cycle after.
